// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED control.
// Redirect targets are formed from the instruction currently held in IF/ID.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        pc_op,
  input  logic        b_jmp,
  input  logic        halt,
  input  logic        if_flush,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic        id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  localparam logic [15:0] BUBBLE = 16'hF000;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_id_instr;
  logic [15:0] r_id_pc;
  logic        r_id_valid;
  logic        r_halted;
  logic [15:0] r_fetch_count;

  state_t      w_state_nxt;
  logic [15:0] w_pc_nxt;
  logic [15:0] w_id_instr_nxt;
  logic [15:0] w_id_pc_nxt;
  logic        w_id_valid_nxt;
  logic [15:0] w_fetch_count_nxt;
  logic [15:0] w_br_off;
  logic [15:0] w_jmp_off;
  logic [15:0] w_target;
  logic        w_redirect;

  // Sign-extended, halfword-scaled offsets taken from the instruction in IF/ID.
  always_comb begin
    w_br_off   = {{7{r_id_instr[7]}}, r_id_instr[7:0], 1'b0};
    w_jmp_off  = {{3{r_id_instr[11]}}, r_id_instr[11:0], 1'b0};
    w_target   = r_id_pc + 16'd2 + (b_jmp ? w_br_off : w_jmp_off);
    w_redirect = pc_op & r_id_valid;
  end

  // Next-state and next-register values; priority halt > redirect > stall > flush > sequential.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_id_instr_nxt    = r_id_instr;
    w_id_pc_nxt       = r_id_pc;
    w_id_valid_nxt    = r_id_valid;
    w_fetch_count_nxt = r_fetch_count;
    case (r_state)
      S_RUN: begin
        if (halt) begin
          w_state_nxt    = S_HALTED;
          w_id_instr_nxt = BUBBLE;
          w_id_valid_nxt = 1'b0;
        end else if (w_redirect) begin
          w_pc_nxt       = w_target;
          w_id_instr_nxt = BUBBLE;
          w_id_valid_nxt = 1'b0;
        end else if (stall) begin
          w_pc_nxt       = r_pc;
        end else if (if_flush) begin
          w_pc_nxt       = r_pc + 16'd2;
          w_id_instr_nxt = BUBBLE;
          w_id_valid_nxt = 1'b0;
        end else begin
          w_pc_nxt          = r_pc + 16'd2;
          w_id_instr_nxt    = imem_data;
          w_id_pc_nxt       = r_pc;
          w_id_valid_nxt    = 1'b1;
          w_fetch_count_nxt = r_fetch_count + 16'd1;
        end
      end
      S_HALTED: begin
        w_state_nxt    = S_HALTED;
        w_id_instr_nxt = BUBBLE;
        w_id_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_id_instr_nxt = BUBBLE;
        w_id_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_pc          <= 16'h0000;
      r_id_instr    <= BUBBLE;
      r_id_pc       <= 16'h0000;
      r_id_valid    <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= 16'h0000;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_id_instr    <= w_id_instr_nxt;
      r_id_pc       <= w_id_pc_nxt;
      r_id_valid    <= w_id_valid_nxt;
      r_halted      <= (w_state_nxt == S_HALTED);
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign imem_addr   = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_valid    = r_id_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: each vector's expected post-edge state is queued
// when the inputs are driven and compared after the clock edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall, pc_op, b_jmp, halt, if_flush;
  logic [15:0] id_instr, id_pc, fetch_count;
  logic        id_valid, halted;

  logic [15:0] mem [0:255];
  int          total = 0;
  int          bad = 0;

  // Control code bit order: {rst_n, halt, pc_op, b_jmp, stall, if_flush}
  localparam logic [5:0] RUN   = 6'b100000;
  localparam logic [5:0] RST   = 6'b000000;
  localparam logic [5:0] FLUSH = 6'b100001;
  localparam logic [5:0] STALL = 6'b100010;
  localparam logic [5:0] BR    = 6'b101100;
  localparam logic [5:0] JMP   = 6'b101000;

  typedef struct {
    logic [5:0]  ctl;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] idpc;
    logic        valid;
    logic        hlt;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .pc_op(pc_op), .b_jmp(b_jmp), .halt(halt), .if_flush(if_flush),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[8:1]];

  function automatic vec_t mk(input logic [5:0] ctl, input logic [15:0] pc, input logic [15:0] ins,
                              input logic [15:0] ip, input logic v, input logic hl, input logic [15:0] c);
    vec_t r;
    r.ctl = ctl; r.pc = pc; r.instr = ins; r.idpc = ip; r.valid = v; r.hlt = hl; r.cnt = c;
    return r;
  endfunction

  function automatic logic [15:0] memword(input logic [15:0] a);
    return mem[a[8:1]];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    {reset, halt, pc_op, b_jmp, stall, if_flush} = v.ctl;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.sb: got empty want entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc"},     imem_addr,            e.pc);
      chk({tag, ".instr"},  id_instr,             e.instr);
      chk({tag, ".idpc"},   id_pc,                e.idpc);
      chk({tag, ".valid"},  {15'd0, id_valid},    {15'd0, e.valid});
      chk({tag, ".halted"}, {15'd0, halted},      {15'd0, e.hlt});
      chk({tag, ".count"},  fetch_count,          e.cnt);
    end
  endtask

  initial begin
    logic [15:0] a;
    {reset, halt, pc_op, b_jmp, stall, if_flush} = 6'b000000;
    for (int i = 0; i < 256; i++) mem[i] = {8'h3C, 8'(i)};
    mem[0]   = 16'h00FE;  // addr 0x0000: branch -2 -> target 0xFFFE
    mem[1]   = 16'h0FF6;  // addr 0x0002: jump -10 -> target 0xFFF0
    mem[8]   = 16'h00FC;  // addr 0x0010: branch -4 -> target 0x000A
    mem[248] = 16'h0010;  // addr 0xFFF0: jump +16 -> target 0x0012

    // Reset overrides everything, sequential fetch, flush, bubble-ignored redirect, branch
    vecs.push_back(mk(6'b011110,         16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(RUN,               16'h0002, 16'h00FE, 16'h0000, 1'b1, 1'b0, 16'd1));
    vecs.push_back(mk(RUN | 6'b000100,   16'h0004, 16'h0FF6, 16'h0002, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mk(RUN,               16'h0006, 16'h3C02, 16'h0004, 1'b1, 1'b0, 16'd3));
    vecs.push_back(mk(FLUSH,             16'h0008, 16'hF000, 16'h0004, 1'b0, 1'b0, 16'd3));
    vecs.push_back(mk(BR,                16'h000A, 16'h3C04, 16'h0008, 1'b1, 1'b0, 16'd4));
    vecs.push_back(mk(RUN,               16'h000C, 16'h3C05, 16'h000A, 1'b1, 1'b0, 16'd5));
    vecs.push_back(mk(RUN,               16'h000E, 16'h3C06, 16'h000C, 1'b1, 1'b0, 16'd6));
    vecs.push_back(mk(RUN,               16'h0010, 16'h3C07, 16'h000E, 1'b1, 1'b0, 16'd7));
    vecs.push_back(mk(RUN,               16'h0012, 16'h00FC, 16'h0010, 1'b1, 1'b0, 16'd8));
    vecs.push_back(mk(BR,                16'h000A, 16'hF000, 16'h0010, 1'b0, 1'b0, 16'd8));
    vecs.push_back(mk(RUN,               16'h000C, 16'h3C05, 16'h000A, 1'b1, 1'b0, 16'd9));
    // Stall holds (and beats flush), then redirect beats stall
    vecs.push_back(mk(STALL,             16'h000C, 16'h3C05, 16'h000A, 1'b1, 1'b0, 16'd9));
    vecs.push_back(mk(STALL | FLUSH,     16'h000C, 16'h3C05, 16'h000A, 1'b1, 1'b0, 16'd9));
    vecs.push_back(mk(STALL,             16'h000C, 16'h3C05, 16'h000A, 1'b1, 1'b0, 16'd9));
    vecs.push_back(mk(STALL | JMP | FLUSH, 16'hF816, 16'hF000, 16'h000A, 1'b0, 1'b0, 16'd9));
    vecs.push_back(mk(RUN,               16'hF818, 16'h3C0B, 16'hF816, 1'b1, 1'b0, 16'd10));
    // Reset mid-stall, then PC wrap via branch to 0xFFFE
    vecs.push_back(mk(RST | 6'b000010,   16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(RUN,               16'h0002, 16'h00FE, 16'h0000, 1'b1, 1'b0, 16'd1));
    vecs.push_back(mk(BR,                16'hFFFE, 16'hF000, 16'h0000, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(RUN,               16'h0000, 16'h3CFF, 16'hFFFE, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mk(RUN,               16'h0002, 16'h00FE, 16'h0000, 1'b1, 1'b0, 16'd3));
    vecs.push_back(mk(RUN,               16'h0004, 16'h0FF6, 16'h0002, 1'b1, 1'b0, 16'd4));
    // Backward jump to 0xFFF0, then forward jump wrapping to 0x0012
    vecs.push_back(mk(JMP,               16'hFFF0, 16'hF000, 16'h0002, 1'b0, 1'b0, 16'd4));
    vecs.push_back(mk(RUN,               16'hFFF2, 16'h0010, 16'hFFF0, 1'b1, 1'b0, 16'd5));
    vecs.push_back(mk(JMP,               16'h0012, 16'hF000, 16'hFFF0, 1'b0, 1'b0, 16'd5));
    vecs.push_back(mk(RUN,               16'h0014, 16'h3C09, 16'h0012, 1'b1, 1'b0, 16'd6));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

    // Halt at PC 0x0020: inputs ignored while halted, reset recovers
    step(mk(RST, 16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0, 16'd0), "h_rst");
    for (int k = 1; k <= 16; k++) begin
      a = 16'(2 * (k - 1));
      step(mk(RUN, 16'(2 * k), memword(a), a, 1'b1, 1'b0, 16'(k)), $sformatf("h_run%0d", k));
    end
    step(mk(6'b111110,      16'h0020, 16'hF000, 16'h001E, 1'b0, 1'b1, 16'd16), "h_enter");
    step(mk(BR | FLUSH,     16'h0020, 16'hF000, 16'h001E, 1'b0, 1'b1, 16'd16), "h_ign0");
    step(mk(STALL,          16'h0020, 16'hF000, 16'h001E, 1'b0, 1'b1, 16'd16), "h_ign1");
    step(mk(RUN,            16'h0020, 16'hF000, 16'h001E, 1'b0, 1'b1, 16'd16), "h_ign2");
    step(mk(RST | 6'b010000, 16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0, 16'd0), "h_reset");
    step(mk(RUN,            16'h0002, 16'h00FE, 16'h0000, 1'b1, 1'b0, 16'd1), "h_after");

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain: got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  reset, synchronous, active-low.
REQ-003 imem_addr  out  16  byte address to instruction memory; equals PC register.
REQ-004 imem_data  in  16  instruction word at imem_addr, combinational (same-cycle) read.
REQ-005 stall  in  1  hazard hold: freeze PC and IF/ID register.
REQ-006 pc_op  in  1  redirect PC this cycle (from control unit, decoding id_instr).
REQ-007 b_jmp  in  1  redirect kind: 1 = branch, 0 = jump; valid only with pc_op.
REQ-008 halt  in  1  stop fetch permanently until reset.
REQ-009 if_flush  in  1  replace next IF/ID contents with bubble.
REQ-010 id_instr  out  16  IF/ID instruction register.
REQ-011 id_pc  out  16  IF/ID address of id_instr.
REQ-012 id_valid  out  1  1 = id_instr is a real fetched instruction, 0 = bubble.
REQ-013 halted  out  1  1 while in HALTED state.
REQ-014 fetch_count  out  16  number of instructions loaded valid into IF/ID since reset.

Function
REQ-015 States SHALL be RUN and HALTED; HALTED exits only via reset.
REQ-016 Bubble SHALL be id_instr = 16'hF000, id_valid = 0; id_pc unchanged.
REQ-017 Fetch latency SHALL be one cycle: word read at PC in cycle n appears on id_instr in cycle n+1 with id_pc = that PC, id_valid = 1.
REQ-018 Sequential update SHALL be PC <= PC + 2, modulo 2^16 (0xFFFE -> 0x0000).
REQ-019 Branch target (pc_op=1, b_jmp=1) SHALL be id_pc + 2 + (sign-extend(id_instr[7:0]) << 1), modulo 2^16.
REQ-020 Jump target (pc_op=1, b_jmp=0) SHALL be id_pc + 2 + (sign-extend(id_instr[11:0]) << 1), modulo 2^16.
REQ-021 On redirect, PC SHALL load the target and IF/ID SHALL load a bubble in the same edge, regardless of if_flush.
REQ-022 Per-edge priority in RUN SHALL be: halt > pc_op > stall > if_flush > sequential.
REQ-023 halt=1 in RUN SHALL: enter HALTED, hold PC, load bubble into IF/ID, ignore pc_op/stall/if_flush that edge.
REQ-024 In HALTED, PC, fetch_count SHALL hold; IF/ID SHALL remain bubble; all inputs except reset ignored.
REQ-025 stall=1 (no halt, no pc_op) SHALL hold PC, id_instr, id_pc, id_valid and fetch_count.
REQ-026 pc_op=1 with stall=1 SHALL redirect (redirect wins; stalled IF/ID content discarded).
REQ-027 if_flush=1 alone SHALL load bubble into IF/ID and advance PC by 2.
REQ-028 fetch_count SHALL increment by 1, wrapping 0xFFFF -> 0x0000, on every edge that loads id_valid = 1.
REQ-029 halted SHALL be a registered output equal to (state == HALTED).
REQ-030 pc_op and b_jmp SHALL be ignored when id_valid = 0 (bubble never redirects).

Reset
REQ-031 On rising edge with reset=0: PC = 0x0000, id_instr = 16'hF000, id_pc = 0x0000, id_valid = 0, fetch_count = 0, state = RUN, halted = 0.
REQ-032 Reset SHALL override all other inputs, including in HALTED and mid-stall.
REQ-033 First cycle after reset release: imem_addr = 0x0000; next edge loads imem_data with id_pc = 0x0000.

Verification
REQ-034 Sequential: release reset, imem returns addr-based words, no controls -> id_pc 0x0000, 0x0002, 0x0004 on successive cycles, fetch_count 1,2,3.
REQ-035 Branch: id_pc = 0x0010, id_instr[7:0] = 0xFC, pc_op=1, b_jmp=1 -> PC = 0x000A, next id_valid = 0, then id_pc = 0x000A.
REQ-036 Jump with wrap: id_pc = 0xFFF0, id_instr[11:0] = 0x010, pc_op=1, b_jmp=0 -> PC = 0x0012.
REQ-037 Stall vs redirect: stall=1 for 3 cycles -> PC, id_* constant; then stall=1 with pc_op=1 -> redirect taken, bubble loaded.
REQ-038 Halt: halt=1 at PC = 0x0020 -> halted = 1 next cycle, PC stays 0x0020, id_valid = 0, pc_op pulses ignored; reset=0 -> all REQ-031 values.
REQ-039 PC wrap: run from PC = 0xFFFE -> next PC = 0x0000, id_pc = 0xFFFE.
